au_serial: RTL and testbench

AU_SERIAL -- requirements
Module: au_serial

---
 rtl/au_serial_if.sv | 37 +++
 rtl/au_serial.sv | 143 ++++++++++++++
 tb/tb_au_serial.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/au_serial_if.sv
// Handshake/operand bundle for au_serial.
// Flag signals exist only when AU_SERIAL_FLAGS_EN is defined.
interface au_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic [1:0]       i_sel;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
`ifdef AU_SERIAL_FLAGS_EN
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sel, i_ready,
`ifdef AU_SERIAL_FLAGS_EN
        output o_zero, o_neg, o_ovf,
`endif
        output o_ready, o_valid, o_result, o_cout
    );

    modport master (
        output i_valid, i_a, i_b, i_cin, i_sel, i_ready,
`ifdef AU_SERIAL_FLAGS_EN
        input  o_zero, o_neg, o_ovf,
`endif
        input  o_ready, o_valid, o_result, o_cout
    );
endinterface

// File: rtl/au_serial.sv
// Digit-serial adder: A + Bsel + cin over WIDTH/DIGIT cycles, LSB digit first.
// Optional zero/neg/ovf flags under AU_SERIAL_FLAGS_EN.
module au_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    au_serial_if.slave  bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  bsel;
    logic [DIGIT:0]    sum;
    logic [WIDTH-1:0]  acc_next;
`ifdef AU_SERIAL_FLAGS_EN
    logic              a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic              zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
`endif

    always_comb begin
        unique case (bus.i_sel)
            2'b00:   bsel = bus.i_b;
            2'b01:   bsel = ~bus.i_b;
            2'b10:   bsel = '0;
            default: bsel = '1;
        endcase
    end

    // Operands shift right one digit per cycle; the sum digit enters acc at the top.
    assign sum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef AU_SERIAL_FLAGS_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a;
                    b_d     = bsel;
                    carry_d = bus.i_cin;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef AU_SERIAL_FLAGS_EN
                    a_msb_d = bus.i_a[WIDTH-1];
                    b_msb_d = bsel[WIDTH-1];
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = sum[DIGIT];
                acc_d   = acc_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    cnt_d    = '0;
                    result_d = acc_next;
                    cout_d   = sum[DIGIT];
`ifdef AU_SERIAL_FLAGS_EN
                    zero_d   = (acc_next == '0);
                    neg_d    = acc_next[WIDTH-1];
                    ovf_d    = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
`endif
                    state_d  = StDone;
                end
            end
            default: begin
                if (bus.i_ready) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef AU_SERIAL_FLAGS_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef AU_SERIAL_FLAGS_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.o_ready  = (state_q == StIdle);
    assign bus.o_valid  = (state_q == StDone);
    assign bus.o_result = result_q;
    assign bus.o_cout   = cout_q;
`ifdef AU_SERIAL_FLAGS_EN
    assign bus.o_zero   = zero_q;
    assign bus.o_neg    = neg_q;
    assign bus.o_ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_au_serial.sv
// Directed bench for au_serial (WIDTH=16, DIGIT=4); flag checks only under AU_SERIAL_FLAGS_EN.
module tb_au_serial;
    logic i_clk;
    logic i_rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] prev_res = 16'h0000;

    au_serial_if #(.WIDTH(16)) bus ();

    au_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input logic ez, input logic en, input logic eo);
`ifdef AU_SERIAL_FLAGS_EN
        check("zero", {31'd0, bus.o_zero}, {31'd0, ez});
        check("neg", {31'd0, bus.o_neg}, {31'd0, en});
        check("ovf", {31'd0, bus.o_ovf}, {31'd0, eo});
`endif
    endtask

    // Accept, scramble inputs during RUN, count latency, check result, handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                          input logic cin, input logic [15:0] er, input logic ec,
                          input logic ez, input logic en, input logic eo);
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_sel = sel; bus.i_cin = cin;
        bus.i_ready = 1'b0;
        @(posedge i_clk); #1;
        check("ready_after_accept", {31'd0, bus.o_ready}, 32'd0);
        check("result_hold_run", {16'd0, bus.o_result}, {16'd0, prev_res});
        bus.i_valid = 1'b0; bus.i_a = ~a; bus.i_b = a ^ b ^ 16'h5A5A; bus.i_sel = ~sel;
        bus.i_cin = ~cin; bus.i_ready = 1'b1;
        repeat (3) begin
            @(posedge i_clk); #1;
            check("valid_early", {31'd0, bus.o_valid}, 32'd0);
        end
        @(posedge i_clk); #1;
        check("valid_at_n", {31'd0, bus.o_valid}, 32'd1);
        check("result", {16'd0, bus.o_result}, {16'd0, er});
        check("cout", {31'd0, bus.o_cout}, {31'd0, ec});
        check_flags(ez, en, eo);
        @(posedge i_clk); #1;
        check("valid_cleared", {31'd0, bus.o_valid}, 32'd0);
        check("ready_idle", {31'd0, bus.o_ready}, 32'd1);
        check("result_hold_idle", {16'd0, bus.o_result}, {16'd0, er});
        bus.i_ready = 1'b0;
        prev_res = er;
    endtask

    initial begin
        i_rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_a = '0; bus.i_b = '0;
        bus.i_sel = 2'b00; bus.i_cin = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_result", {16'd0, bus.o_result}, 32'd0);
        check("rst_cout", {31'd0, bus.o_cout}, 32'd0);
        check_flags(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_op(16'h1234, 16'h0FFF, 2'b00, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 2'b01, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(16'h0007, 16'h0007, 2'b01, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h1234, 2'b10, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op(16'h0000, 16'h1234, 2'b11, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(16'h1234, 16'h1234, 2'b01, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Backpressure with i_valid held high through RUN and DONE
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_a = 16'h00FF; bus.i_b = 16'h0001; bus.i_sel = 2'b00;
        bus.i_cin = 1'b0; bus.i_ready = 1'b0;
        @(posedge i_clk); #1;
        bus.i_a = 16'h0001; bus.i_b = 16'h0001;
        repeat (3) @(posedge i_clk);
        @(posedge i_clk); #1;
        check("bp_valid", {31'd0, bus.o_valid}, 32'd1);
        check("bp_result", {16'd0, bus.o_result}, 32'h0100);
        repeat (3) begin
            @(posedge i_clk); #1;
            check("bp_hold_valid", {31'd0, bus.o_valid}, 32'd1);
            check("bp_hold_result", {16'd0, bus.o_result}, 32'h0100);
            check("bp_ready_low", {31'd0, bus.o_ready}, 32'd0);
        end
        bus.i_ready = 1'b1;
        @(posedge i_clk); #1;
        check("bp_release_valid", {31'd0, bus.o_valid}, 32'd0);
        check("bp_release_ready", {31'd0, bus.o_ready}, 32'd1);
        bus.i_ready = 1'b0;
        @(posedge i_clk); #1;
        check("bp_reaccept", {31'd0, bus.o_ready}, 32'd0);
        bus.i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(posedge i_clk); #1;
        check("bp2_valid", {31'd0, bus.o_valid}, 32'd1);
        check("bp2_result", {16'd0, bus.o_result}, 32'h0002);
        bus.i_ready = 1'b1;
        @(posedge i_clk); #1;
        check("bp2_done", {31'd0, bus.o_valid}, 32'd0);
        bus.i_ready = 1'b0;
        prev_res = 16'h0002;

        // Reset mid-RUN aborts the operation
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_a = 16'hF000; bus.i_b = 16'h0F00; bus.i_sel = 2'b00;
        bus.i_cin = 1'b1;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("mid_rst_result", {16'd0, bus.o_result}, 32'd0);
        check("mid_rst_cout", {31'd0, bus.o_cout}, 32'd0);
        check_flags(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (8) begin
            @(posedge i_clk); #1;
            check("post_rst_no_valid", {31'd0, bus.o_valid}, 32'd0);
            check("post_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        end
        prev_res = 16'h0000;
        run_op(16'h0100, 16'h0023, 2'b00, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
